// File: rtl/led_pattern_sched.sv
// led_pattern_sched: round-robin scheduler of two pattern requesters onto an 8-LED bank.
// Define LED_PWM_EN to add per-command 4-bit brightness PWM on the LED outputs.
module led_pattern_sched #(
    parameter int CLK_DIV = 25_000_000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_mode,
    input  logic [7:0]       req0_pattern,
    input  logic [CNT_W-1:0] req0_count,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_mode,
    input  logic [7:0]       req1_pattern,
    input  logic [CNT_W-1:0] req1_count,
`ifdef LED_PWM_EN
    input  logic [3:0]       req0_bright,
    input  logic [3:0]       req1_bright,
`endif
    output logic [7:0]       leds,
    output logic             busy,
    output logic             grant_id,
    output logic             done
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] step_q, step_d, count_q, count_d, a_count;
    logic [7:0]       pat_q, pat_d, base_q, base_d, a_pat, nxt_pat;
    logic [1:0]       mode_q, mode_d, a_mode;
    logic             last_q, last_d, gid_q, gid_d;
    logic             sel, accept, tick;
    // When both are valid the winner is whoever did not win last time.
    assign sel        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = !rst && state_q == IDLE && req0_valid && !sel;
    assign req1_ready = !rst && state_q == IDLE && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;
    assign a_mode     = sel ? req1_mode : req0_mode;
    assign a_pat      = sel ? req1_pattern : req0_pattern;
    assign a_count    = sel ? req1_count : req0_count;
    assign tick       = presc_q == PW'(CLK_DIV - 1);
    // Blink restores the latched pattern on odd-to-even step transitions.
    assign nxt_pat = mode_q == 2'd0 ? pat_q :
                     mode_q == 2'd1 ? (step_q[0] ? base_q : 8'h00) :
                     mode_q == 2'd2 ? {pat_q[6:0], pat_q[7]} :
                                      {pat_q[0], pat_q[7:1]};
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        step_d  = step_q;
        count_d = count_q;
        pat_d   = pat_q;
        base_d  = base_q;
        mode_d  = mode_q;
        last_d  = last_q;
        gid_d   = gid_q;
        case (state_q)
            IDLE: if (accept) begin
                last_d  = sel;
                gid_d   = sel;
                count_d = a_count;
                mode_d  = a_mode;
                base_d  = a_pat;
                presc_d = '0;
                step_d  = '0;
                state_d = a_count == '0 ? DONE : RUN;
                pat_d   = a_count == '0 ? 8'h00 : a_pat;
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick && step_q == count_q - CNT_W'(1)) begin
                    state_d = DONE;
                    pat_d   = 8'h00;
                end else if (tick) begin
                    step_d = step_q + CNT_W'(1);
                    pat_d  = nxt_pat;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            step_q  <= '0;
            count_q <= '0;
            pat_q   <= '0;
            base_q  <= '0;
            mode_q  <= '0;
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            count_q <= count_d;
            pat_q   <= pat_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
        end
    end
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign grant_id = gid_q;
`ifdef LED_PWM_EN
    logic [3:0] pwm_q, bright_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q    <= '0;
            bright_q <= '0;
        end else begin
            pwm_q    <= pwm_q + 4'd1;
            bright_q <= accept ? (sel ? req1_bright : req0_bright) : bright_q;
        end
    end
    assign leds = state_q == RUN ? pat_q & {8{pwm_q < bright_q}} : 8'h00;
`else
    assign leds = pat_q;
`endif
endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: directed scoreboard bench for led_pattern_sched with CLK_DIV=4.
module tb_led_pattern_sched;
    localparam int DIV = 4;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_mode, req1_mode;
    logic [7:0] req0_pattern, req1_pattern, req0_count, req1_count;
    logic [7:0] leds;
    logic       busy, grant_id, done;
    int         total = 0;
    int         bad = 0;
    typedef struct {logic [7:0] leds; logic done;} exp_t;
    exp_t sb[$];

    led_pattern_sched #(.CLK_DIV(DIV), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_pattern(req0_pattern), .req0_count(req0_count),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_pattern(req1_pattern), .req1_count(req1_count),
        .leds(leds), .busy(busy), .grant_id(grant_id), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit r, input logic v, input logic [1:0] m,
                           input logic [7:0] p, input logic [7:0] c);
        if (r) begin
            req1_valid = v; req1_mode = m; req1_pattern = p; req1_count = c;
        end else begin
            req0_valid = v; req0_mode = m; req0_pattern = p; req0_count = c;
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Waits (bounded) for the requester's ready, then returns in the first cycle after acceptance.
    task automatic accept(input bit r, input bit rearm, output bit ok);
        int w = 0;
        #1;
        while (!(r ? req1_ready : req0_ready) && w < 2000) begin
            tick();
            w++;
        end
        ok = w < 2000;
        chk("accept_wait", 16'(w), 16'd0);
        chk("other_ready", r ? req0_ready : req1_ready, 1'b0);
        tick();
        if (!rearm) set_req(r, 1'b0, 2'd0, 8'h00, 8'd0);
    endtask

    task automatic run_cmd(input bit r, input logic [1:0] m, input logic [7:0] p,
                           input logic [7:0] c, input bit rearm);
        logic [7:0] q = p;
        bit ok;
        exp_t e;
        set_req(r, 1'b1, m, p, c);
        for (int i = 0; i < int'(c); i++) begin
            for (int k = 0; k < DIV; k++)
                sb.push_back('{(m == 2'd1) ? ((i % 2 == 0) ? p : 8'h00) : q, 1'b0});
            q = (m == 2'd2) ? {q[6:0], q[7]} : (m == 2'd3) ? {q[0], q[7:1]} : q;
        end
        sb.push_back('{8'h00, 1'b1});
        accept(r, rearm, ok);
        if (!ok) sb.delete();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("leds", leds, e.leds);
            chk("done", done, e.done);
            chk("busy", busy, 1'b1);
            chk("grant_id", grant_id, r);
            tick();
        end
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_leds", leds, 8'h00);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        set_req(0, 1'b1, 2'd2, 8'h01, 8'd4);
        set_req(1, 1'b1, 2'd0, 8'h3C, 8'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_leds", leds, 8'h00);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_grant", grant_id, 1'b0);
            chk("rst_ready0", req0_ready, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("ready0_after_rst", req0_ready, 1'b1);
        // Both valid after reset: requester 0 first, then 1; both re-request and 0 wins again.
        run_cmd(0, 2'd2, 8'h01, 8'd4, 1'b0);
        set_req(0, 1'b1, 2'd1, 8'hA5, 8'd3);
        run_cmd(1, 2'd0, 8'h3C, 8'd1, 1'b1);
        run_cmd(0, 2'd1, 8'hA5, 8'd3, 1'b0);
        run_cmd(1, 2'd0, 8'h3C, 8'd1, 1'b0);
        run_cmd(0, 2'd3, 8'h01, 8'd2, 1'b0);
        run_cmd(1, 2'd2, 8'h80, 8'd3, 1'b0);
        run_cmd(0, 2'd0, 8'h5A, 8'd0, 1'b0);
        run_cmd(1, 2'd2, 8'h81, 8'd255, 1'b0);
        // Reset in the middle of a RUN step drops the command silently.
        set_req(0, 1'b1, 2'd2, 8'h0F, 8'd5);
        accept(0, 1'b0, ok);
        chk("mid_leds0", leds, 8'h0F);
        tick();
        chk("mid_leds1", leds, 8'h0F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_leds", leds, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_pattern_sched.md
Name: led_pattern_sched

Overview:
- Schedules the 8-LED bank between two requesters.
- Each requester submits a pattern command over a valid/ready handshake, and a round-robin arbiter grants one command at a time.
- The granted command runs a stepped pattern (static, blink, chase left, chase right) at a prescaled step rate, then pulses done and releases the LEDs.
- Sits between control logic and the board LED pins.

Parameters:
- CLK_DIV, 25_000_000: clock cycles per pattern step. Must be >= 1. Benches override it to 4.
- CNT_W, 8: width of the step-count field.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_mode  in  2  0=STATIC, 1=BLINK, 2=CHASE_L, 3=CHASE_R.
- req0_pattern  in  8  initial LED pattern.
- req0_count  in  CNT_W  number of steps to display.
- req1_valid, req1_ready, req1_mode, req1_pattern, req1_count: same as requester 0, for requester 1.
- leds  out  8  LED drive; 1 = lit.
- busy  out  1  high in RUN and DONE.
- grant_id  out  1  owner of the current or last command.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset values: leds=0, busy=0, done=0, grant_id=0, state=IDLE, prescaler=0, step_cnt=0, last_grant=1 (so requester 0 wins first).
- Reset is also applied mid-run: any command in progress is dropped with no done pulse.
- Handshake:
  - reqN_ready is combinational and can be high only in IDLE.
  - At most one ready is high per cycle.
  - Transfer happens when valid && ready at a clock edge.
  - A requester holds valid and payload stable until accepted; valid must not depend on ready.
- Arbitration (IDLE only):
  - Only one requester valid: it is granted.
  - Both valid: grant the one not equal to last_grant.
  - On accept, last_grant and grant_id are set to the winner.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on accept with count != 0:
  - Pattern register is loaded with reqN_pattern; mode and count are latched.
  - prescaler=0, step_cnt=0.
  - leds shows the pattern in the first cycle after the accept edge.
- IDLE -> DONE on accept with count == 0: leds stays 0.
- RUN:
  - prescaler counts 0..CLK_DIV-1; a tick occurs when prescaler==CLK_DIV-1, then prescaler wraps to 0.
  - On a tick with step_cnt==count-1: go to DONE, leds<=0.
  - Otherwise step_cnt+=1 and the pattern is updated per mode:
    - STATIC: unchanged.
    - BLINK: alternates between the latched pattern and 0x00.
    - CHASE_L: rotate left by 1 (bit7 wraps to bit0).
    - CHASE_R: rotate right by 1 (bit0 wraps to bit7).
- Step timing: each step is exactly CLK_DIV cycles. With the accept edge at cycle T and count=N, done=1 during cycle T+1+N*CLK_DIV.
- DONE: lasts exactly 1 cycle with done=1, busy=1, leds=0, then returns to IDLE. A new accept is possible on the IDLE cycle that follows.
- Requests arriving during RUN/DONE wait (ready=0) and are never dropped.
- count=2^CNT_W-1 runs the full 255 steps without wrap errors.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - Adds inputs req0_bright[3:0] and req1_bright[3:0]; brightness is latched on accept.
  - Adds a free-running 4-bit pwm_cnt (reset 0, +1 every clk).
  - leds = pattern & {8{pwm_cnt < bright}}, so brightness 0 = dark and 15 = 15/16 duty.
  - leds is forced 0 in IDLE/DONE regardless of pwm_cnt.
- Undefined: no bright ports and no pwm_cnt; leds equals the pattern register directly.

Test Plan (CLK_DIV=4):
- Reset and idle: assert rst for 2 cycles with req0_valid=1 -> leds=0x00, busy=0, done=0, grant_id=0, req0_ready=0 during rst and 1 in the first idle cycle after release.
- CHASE_L: req0 pattern 0x01, count 4, accepted at T -> leds 0x01, 0x02, 0x04, 0x08, each for 4 cycles starting T+1; done=1 and leds=0 at T+17; IDLE at T+18.
- Arbitration: req0 and req1 both valid after reset -> req0 accepted first (grant_id=0); req1 accepted on the IDLE cycle after req0's done (grant_id=1); with both re-requesting, req0 wins next.
- BLINK and CHASE_R wrap: BLINK 0xA5 count 3 -> 0xA5, 0x00, 0xA5; CHASE_R 0x01 count 2 -> 0x01, 0x80.
- count=0 and reset mid-run: count 0 accepted at T -> done at T+1, leds stays 0. rst asserted during a RUN step -> next cycle leds=0, busy=0, no done pulse.
- LED_PWM_EN: bright=4, pattern 0xFF -> leds=0xFF for 4 of every 16 cycles; bright=0 -> leds=0 throughout.
